i2sm_rx: RTL and testbench

- I2S master receiver; the capture-side counterpart of the I2S master transmitter.
- Runs entirely in the 12.288 MHz MCLK domain, clocked on `clk`.
- Generates `sclk` and `lrclk` for an external ADC, deserialises standard I2S data (MSB one SCLK after the LRCLK edge) and presents left/right sample pairs on a valid/ready output, normally feeding the write side of an async FIFO.

---
 rtl/i2sm_rx_if.sv | 19 +
 rtl/i2sm_rx.sv | 129 ++++++++++++
 tb/tb_i2sm_rx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2sm_rx_if.sv
// ==========================================================================
// i2sm_rx_if : sample-pair valid/ready bus out of the I2S receiver
// rev 1.0
// ==========================================================================
`default_nettype none

interface i2sm_rx_if #(
  parameter int DW = 24
);
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_left;
  logic [DW-1:0] o_right;

  modport master (output o_valid, output o_left, output o_right, input  i_ready);
  modport slave  (input  o_valid, input  o_left, input  o_right, output i_ready);
endinterface

`default_nettype wire

// File: rtl/i2sm_rx.sv
// ==========================================================================
// i2sm_rx : I2S master receiver, generates SCLK/LRCLK and deserialises pairs
// rev 1.0
// ==========================================================================
`default_nettype none

module i2sm_rx #(
  parameter int DW        = 24,
  parameter int SLOT_BITS = 32,
  parameter int SCLK_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       sclk_o,
  output logic       lrclk_o,
  input  logic       sdata_i,
  i2sm_rx_if.master  bus,
  output logic       o_overrun
);

  localparam int DIVW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BITW = $clog2(2 * SLOT_BITS);

  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(SCLK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF  = DIVW'(SCLK_DIV / 2);
  localparam logic [BITW-1:0] BIT_LAST  = BITW'(2 * SLOT_BITS - 1);
  localparam logic [BITW-1:0] SLOT      = BITW'(SLOT_BITS);
  localparam logic [BITW-1:0] DW_B      = BITW'(DW);
  localparam logic [BITW-1:0] RIGHT_END = BITW'(SLOT_BITS + DW);

  logic [DIVW-1:0] div_q,   div_d;
  logic [BITW-1:0] bit_q,   bit_d;
  logic            sclk_q,  sclk_d;
  logic            lrclk_q, lrclk_d;
  logic [DW-1:0]   sh_q,    sh_d;
  logic [DW-1:0]   lhold_q, lhold_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   left_q,  left_d;
  logic [DW-1:0]   right_q, right_d;
  logic            ovr_q,   ovr_d;

  logic            cap;
  logic            pair_done;
  logic [BITW-1:0] slot_k;

  always_comb begin
    cap    = en && (div_q == DIV_LAST);
    slot_k = (bit_q >= SLOT) ? (bit_q - SLOT) : bit_q;

    div_d = '0;
    bit_d = '0;
    if (en) begin
      div_d = cap ? '0 : div_q + 1'b1;
      bit_d = bit_q;
      if (cap) begin
        bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
      end
    end

    // Clock outputs track the next counter values so they line up with them
    sclk_d  = (div_d >= DIV_HALF);
    lrclk_d = (bit_d >= SLOT);

    sh_d = en ? sh_q : '0;
    if (cap && (slot_k != '0) && (slot_k <= DW_B)) begin
      sh_d = (sh_q << 1) | DW'(sdata_i);
    end

    lhold_d = en ? lhold_q : '0;
    if (cap && (bit_q == DW_B)) begin
      lhold_d = sh_d;
    end

    pair_done = cap && (bit_q == RIGHT_END);

    valid_d = valid_q;
    left_d  = left_q;
    right_d = right_q;
    ovr_d   = ovr_q;
    if (pair_done) begin
      if (!valid_q || bus.i_ready) begin
        valid_d = 1'b1;
        left_d  = lhold_q;
        right_d = sh_d;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sh_q    <= '0;
      lhold_q <= '0;
      valid_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      lrclk_q <= lrclk_d;
      sh_q    <= sh_d;
      lhold_q <= lhold_d;
      valid_q <= valid_d;
      left_q  <= left_d;
      right_q <= right_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sclk_o      = sclk_q;
  assign lrclk_o     = lrclk_q;
  assign bus.o_valid = valid_q;
  assign bus.o_left  = left_q;
  assign bus.o_right = right_q;
  assign o_overrun   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_i2sm_rx.sv
// ==========================================================================
// tb_i2sm_rx : randomized bench for i2sm_rx with a frame-level reference model
// rev 1.0
// ==========================================================================
`default_nettype none

module tb_i2sm_rx;

  localparam int DW        = 24;
  localparam int SLOT_BITS = 32;
  localparam int SCLK_DIV  = 4;
  localparam int FRAME     = 2 * SLOT_BITS * SCLK_DIV;
  localparam int PAIR_T    = (SLOT_BITS + DW) * SCLK_DIV + SCLK_DIV - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic sdata = 1'b0;
  logic sclk, lrclk, ovr;

  i2sm_rx_if #(.DW(DW)) bus ();

  i2sm_rx #(.DW(DW), .SLOT_BITS(SLOT_BITS), .SCLK_DIV(SCLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sclk_o    (sclk),
    .lrclk_o   (lrclk),
    .sdata_i   (sdata),
    .bus       (bus),
    .o_overrun (ovr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  bit fixed_words = 1'b0;

  // Reference model: t is the position within the frame, advancing only while enabled
  int            t = 0;
  logic          m_valid = 1'b0, m_ovr = 1'b0;
  logic [DW-1:0] m_left = '0, m_right = '0;
  logic [DW-1:0] cur_l = '0, cur_r = '0;

  always @(posedge clk) begin
    if (rst) begin
      t = 0; m_valid = 1'b0; m_ovr = 1'b0; m_left = '0; m_right = '0;
    end else begin
      if (en && t == PAIR_T) begin
        if (!m_valid || bus.i_ready) begin
          m_valid = 1'b1; m_left = cur_l; m_right = cur_r;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && bus.i_ready) begin
        m_valid = 1'b0;
      end
      t = en ? (t + 1) % FRAME : 0;
    end
    if (t == 0) begin
      if (fixed_words) begin
        cur_l = 24'hA5A5A5; cur_r = 24'h123456;
      end else begin
        cur_l = DW'($urandom); cur_r = DW'($urandom);
      end
    end
  end

  // ADC model: bit k of a slot carries word bit DW-k, everything else is junk
  int            a_b, a_k;
  logic [DW-1:0] a_w;
  always @(negedge clk) begin
    a_b = t / SCLK_DIV;
    a_k = a_b % SLOT_BITS;
    a_w = (a_b >= SLOT_BITS) ? cur_r : cur_l;
    if (a_k >= 1 && a_k <= DW) sdata = a_w[DW-a_k];
    else                       sdata = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("sclk",    32'(sclk),  32'((t % SCLK_DIV) >= SCLK_DIV / 2));
      chk("lrclk",   32'(lrclk), 32'(t >= FRAME / 2));
      chk("valid",   32'(bus.o_valid), 32'(m_valid));
      chk("overrun", 32'(ovr),   32'(m_ovr));
      chk("left",    32'(bus.o_left),  32'(m_left));
      chk("right",   32'(bus.o_right), 32'(m_right));
    end
  end

  int cyc = 0;

  task automatic wait_neg(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic at_start(input int c);
    wait_neg(c - 1);
    @(posedge clk);
    #1;
  endtask

  task automatic start_en();
    @(posedge clk);
    #1;
    en  = 1'b1;
    cyc = -1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; en = 1'b0; bus.i_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    bus.i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1'b1;

    // Basic capture with known words
    fixed_words = 1'b1;
    bus.i_ready = 1'b1;
    repeat (8) @(posedge clk);
    start_en();
    wait_neg(0);   chk("lit sclk c0", 32'(sclk), 32'd0);
    wait_neg(2);   chk("lit sclk c2", 32'(sclk), 32'd1);
    wait_neg(127); chk("lit lrclk c127", 32'(lrclk), 32'd0);
    wait_neg(128); chk("lit lrclk c128", 32'(lrclk), 32'd1);
    wait_neg(227); chk("lit valid c227", 32'(bus.o_valid), 32'd0);
    wait_neg(228);
    chk("lit valid c228", 32'(bus.o_valid), 32'd1);
    chk("lit left c228",  32'(bus.o_left),  32'h00A5A5A5);
    chk("lit right c228", 32'(bus.o_right), 32'h00123456);
    wait_neg(229); chk("lit valid c229", 32'(bus.o_valid), 32'd0);
    wait_neg(484); chk("lit valid c484", 32'(bus.o_valid), 32'd1);
    wait_neg(800); chk("lit ovr c800", 32'(ovr), 32'd0);

    // Backpressure and overrun
    fixed_words = 1'b0;
    do_reset();
    start_en();
    wait_neg(228); chk("lit bp valid c228", 32'(bus.o_valid), 32'd1);
    wait_neg(483); chk("lit bp ovr c483", 32'(ovr), 32'd0);
    wait_neg(484); chk("lit bp ovr c484", 32'(ovr), 32'd1);
    at_start(600); bus.i_ready = 1'b1;
    wait_neg(601); chk("lit bp valid c601", 32'(bus.o_valid), 32'd0);
    wait_neg(740);
    chk("lit bp valid c740", 32'(bus.o_valid), 32'd1);
    chk("lit bp ovr c740",   32'(ovr), 32'd1);

    // Transfer coinciding with a new pair
    do_reset();
    start_en();
    at_start(483); bus.i_ready = 1'b1;
    at_start(484); bus.i_ready = 1'b0;
    wait_neg(484);
    chk("lit sim valid", 32'(bus.o_valid), 32'd1);
    chk("lit sim ovr",   32'(ovr), 32'd0);
    wait_neg(490); chk("lit sim valid c490", 32'(bus.o_valid), 32'd1);

    // Enable abort mid-frame
    do_reset();
    bus.i_ready = 1'b1;
    start_en();
    at_start(150); en = 1'b0;
    wait_neg(152);
    chk("lit abort sclk", 32'(sclk), 32'd0);
    chk("lit abort lrclk", 32'(lrclk), 32'd0);
    at_start(160); en = 1'b1;
    wait_neg(228); chk("lit abort no valid", 32'(bus.o_valid), 32'd0);
    wait_neg(387); chk("lit abort valid c387", 32'(bus.o_valid), 32'd0);
    wait_neg(388); chk("lit abort valid c388", 32'(bus.o_valid), 32'd1);

    // Reset with a pending pair and a set overrun flag
    do_reset();
    start_en();
    at_start(500); rst = 1'b1;
    at_start(501); rst = 1'b0;
    wait_neg(501);
    chk("lit rst valid", 32'(bus.o_valid), 32'd0);
    chk("lit rst ovr",   32'(ovr), 32'd0);
    chk("lit rst left",  32'(bus.o_left), 32'd0);
    wait_neg(728); chk("lit rst valid c728", 32'(bus.o_valid), 32'd0);
    wait_neg(729); chk("lit rst valid c729", 32'(bus.o_valid), 32'd1);

    // Randomized run: varying ready pressure and occasional enable drops
    do_reset();
    start_en();
    for (int i = 0; i < 9000; i++) begin
      int pct;
      pct = 20 + 25 * ((i / 1000) % 4);
      @(posedge clk);
      #1;
      bus.i_ready = ($urandom_range(0, 99) < pct);
      if ($urandom_range(0, 2999) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
    end
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
